// File: rtl/mips_br_pkg.sv
// Shared encodings for branch resolution: op codes, compare codes, FSM states.
// Also holds the target-address helper used by the resolve stage.
package mips_br_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;
  localparam logic [2:0] BR_RSVD = 3'b111;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b10;
  localparam logic [1:0] CMP_LT = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLOT  = 2'd1,
    REDIR = 2'd2
  } br_state_t;

  function automatic logic is_branch(input logic [2:0] op);
    return (op != BR_NONE) && (op != BR_RSVD);
  endfunction

  // Word offset relative to the delay-slot PC; overflow wraps silently.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] off);
    return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/br_cond.sv
// Branch condition decode: (op, compare code, rs sign) -> taken.
// Purely combinational, zero latency, no flow control.
module br_cond
  import mips_br_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] cmp,
  input  logic       sign,
  output logic       taken
);

  logic z;

  assign z = (cmp == CMP_EQ);

  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = z;
      BR_BNE:  taken = !z;
      BR_BLEZ: taken = sign | z;
      BR_BGTZ: taken = !sign & !z;
      BR_BLTZ: taken = sign;
      BR_BGEZ: taken = !sign;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve.sv
// Branch resolve stage: decides taken/target, tracks the delay slot, pulses a fetch redirect.
// Latency 1 cycle into a one-entry slot; in_ready = !out_valid | out_ready, outputs hold under stall.
module br_resolve
  import mips_br_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_cmp,
  input  logic             in_rs_sign,
  input  logic [31:0]      in_pc,
  input  logic [15:0]      in_offset,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [31:0]      out_target,
  output logic [31:0]      out_pc,
  output logic             redirect_vld,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  br_state_t   state_q;
  br_state_t   state_nxt;
  logic [31:0] tgt_q;
  logic        br_q;
  logic        xfer;
  logic        load;
  logic        cond_taken;
  logic        slot_load;

  assign in_ready = !out_valid | out_ready;
  assign xfer     = out_valid & out_ready;
  assign load     = in_valid & in_ready & !flush;

  br_cond u_cond (
    .op    (in_op),
    .cmp   (in_cmp),
    .sign  (in_rs_sign),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE, REDIR: state_nxt = (xfer && out_taken) ? SLOT : IDLE;
        SLOT:        if (xfer) state_nxt = REDIR;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    redirect_vld = (state_q == REDIR) && !flush;
    redirect_pc  = (state_q == REDIR) ? tgt_q : 32'd0;
  end

  // An entry loaded in the same cycle its taken predecessor leaves is already
  // the delay slot, so the slot test looks at the state the FSM is heading into.
  assign slot_load = (state_nxt == SLOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_taken  <= 1'b0;
      out_target <= 32'd0;
      out_pc     <= 32'd0;
      br_q       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_taken  <= cond_taken & !slot_load;
      out_target <= br_target(in_pc, in_offset);
      out_pc     <= in_pc;
      br_q       <= is_branch(in_op);
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= 32'd0;
    end else if (!flush && xfer && out_taken && (state_q != SLOT)) begin
      tgt_q <= out_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt <= '0;
      tk_cnt <= '0;
    end else if (!flush && xfer && br_q) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_ONE;
      if (out_taken && (tk_cnt != '1)) tk_cnt <= tk_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: hand-computed vectors checked with immediate assertions.
// Counters are built 2 bits wide so saturation is reachable in a few transfers.
module tb_br_resolve;
  import mips_br_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_cmp;
  logic        in_rs_sign;
  logic [31:0] in_pc;
  logic [15:0] in_offset;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic [31:0] out_pc;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic [1:0]  br_cnt;
  logic [1:0]  tk_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  br_resolve #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_cmp       (in_cmp),
    .in_rs_sign   (in_rs_sign),
    .in_pc        (in_pc),
    .in_offset    (in_offset),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_taken    (out_taken),
    .out_target   (out_target),
    .out_pc       (out_pc),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .br_cnt       (br_cnt),
    .tk_cnt       (tk_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] cmp,
                       input logic sg, input logic [31:0] pc, input logic [15:0] off);
    in_valid   = v;
    in_op      = op;
    in_cmp     = cmp;
    in_rs_sign = sg;
    in_pc      = pc;
    in_offset  = off;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, BR_NONE, CMP_EQ, 1'b0, 32'd0, 16'd0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_redirect", 32'(redirect_vld), 32'd0);
    chk("rst_br_cnt", {30'd0, br_cnt}, 32'd0);
    chk("rst_tk_cnt", {30'd0, tk_cnt}, 32'd0);
    #1 rst = 1'b0;

    // BEQ taken, target = 0x400000 + 4 + 16
    drive(1'b1, BR_BEQ, CMP_EQ, 1'b0, 32'h0040_0000, 16'h0004);
    tick();
    chk("beq_valid", 32'(out_valid), 32'd1);
    chk("beq_taken", 32'(out_taken), 32'd1);
    chk("beq_target", out_target, 32'h0040_0014);
    chk("beq_pc", out_pc, 32'h0040_0000);
    chk("beq_stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("beq_xfer_br", {30'd0, br_cnt}, 32'd1);
    chk("beq_xfer_tk", {30'd0, tk_cnt}, 32'd1);
    chk("beq_no_redirect_yet", 32'(redirect_vld), 32'd0);

    // NONE in the delay slot, then redirect
    drive(1'b1, BR_NONE, CMP_EQ, 1'b0, 32'h0040_0004, 16'h0000);
    tick();
    in_valid = 1'b0;
    tick();
    chk("slot1_redirect", 32'(redirect_vld), 32'd1);
    chk("slot1_redirect_pc", redirect_pc, 32'h0040_0014);
    chk("slot1_none_not_counted", {30'd0, br_cnt}, 32'd1);
    tick();
    chk("slot1_redirect_one_cycle", 32'(redirect_vld), 32'd0);

    // BGTZ with negative rs not taken; BLTZ with same inputs taken
    drive(1'b1, BR_BGTZ, CMP_GT, 1'b1, 32'h0000_1000, 16'hFFFE);
    tick();
    chk("bgtz_neg_taken", 32'(out_taken), 32'd0);
    in_op = BR_BLTZ;
    tick();
    chk("bltz_neg_taken", 32'(out_taken), 32'd1);
    chk("bltz_target", out_target, 32'h0000_0FFC);
    chk("bgtz_counted_br", {30'd0, br_cnt}, 32'd2);
    chk("bgtz_counted_tk", {30'd0, tk_cnt}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bltz_br_cnt", {30'd0, br_cnt}, 32'd3);
    chk("bltz_tk_cnt", {30'd0, tk_cnt}, 32'd2);

    // Flush while in SLOT with a simultaneous input
    flush = 1'b1;
    drive(1'b1, BR_BEQ, CMP_EQ, 1'b0, 32'h0000_2000, 16'h0000);
    #1;
    chk("flush_cycle_redirect", 32'(redirect_vld), 32'd0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("flush_no_redirect", 32'(redirect_vld), 32'd0);
    chk("flush_dropped_input", 32'(out_valid), 32'd0);
    chk("flush_keeps_br_cnt", {30'd0, br_cnt}, 32'd3);

    // BNE near the top of the address space; slot BNE wraps to 0
    drive(1'b1, BR_BNE, CMP_GT, 1'b0, 32'hFFFF_FFF0, 16'h0000);
    tick();
    chk("bne_after_flush_taken", 32'(out_taken), 32'd1);
    chk("bne_target", out_target, 32'hFFFF_FFF4);
    in_offset = 16'h0003;
    tick();
    chk("slot_bne_valid", 32'(out_valid), 32'd1);
    chk("slot_bne_forced", 32'(out_taken), 32'd0);
    chk("slot_bne_wrap", out_target, 32'h0000_0000);
    chk("bne_tk_sat", {30'd0, tk_cnt}, 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("slot_stall_redirect", 32'(redirect_vld), 32'd0);
      chk("slot_stall_hold", out_target, 32'h0000_0000);
    end
    out_ready = 1'b1;
    tick();
    chk("slot2_redirect", 32'(redirect_vld), 32'd1);
    chk("slot2_redirect_pc", redirect_pc, 32'hFFFF_FFF4);
    chk("slot2_tk_held", {30'd0, tk_cnt}, 32'd3);
    tick();
    chk("slot2_redirect_one_cycle", 32'(redirect_vld), 32'd0);

    // Counter saturation from a fresh reset
    rst = 1'b1;
    #1;
    chk("rst2_br_cnt", {30'd0, br_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, BR_BEQ, CMP_EQ, 1'b0, 32'h0000_2000, 16'h0001);
      tick();
      in_op = BR_NONE;
      tick();
      in_valid = 1'b0;
      tick();
      if (i == 1) begin
        chk("sat_mid_br", {30'd0, br_cnt}, 32'd2);
        chk("sat_mid_tk", {30'd0, tk_cnt}, 32'd2);
      end
    end
    chk("sat_br", {30'd0, br_cnt}, 32'd3);
    chk("sat_tk", {30'd0, tk_cnt}, 32'd3);
    chk("sat_redirect_pc", redirect_pc, 32'h0000_2008);
    tick();
    tick();
    chk("sat_br_held", {30'd0, br_cnt}, 32'd3);
    chk("sat_tk_held", {30'd0, tk_cnt}, 32'd3);

    // Asynchronous reset with a pending entry
    out_ready = 1'b0;
    drive(1'b1, BR_BEQ, CMP_EQ, 1'b0, 32'h0000_3000, 16'h0002);
    tick();
    chk("pre_arst_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_taken", 32'(out_taken), 32'd0);
    chk("arst_out_target", out_target, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_br_cnt", {30'd0, br_cnt}, 32'd0);
    chk("arst_tk_cnt", {30'd0, tk_cnt}, 32'd0);
    chk("arst_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
